// File: rtl/fifo_uart_tx_pkg.sv
// Shared state types and line levels for the FIFO-fed UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    typedef enum logic {
        H_IDLE,
        H_ACK
    } hs_state_t;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Free-running baud divider; tick marks the last clk cycle of each bit time.
module baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Serial frame transmitter fed by a four-phase FIFO handshake.
// Optional even-parity bit enabled with the UART_TX_PARITY_EN macro.
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 8,
    parameter int BIT_WIDTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_rdy,
    output logic             in_done,
    input  logic [WIDTH-1:0] in_data,
    output logic             txd,
    output logic             busy
);

    tx_state_t            state, state_next;
    hs_state_t            hs, hs_next;
    logic [WIDTH-1:0]     shreg;
    logic [BIT_WIDTH-1:0] bit_idx;
    logic                 tick;
    logic                 accept;
    logic                 last_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    // A new word may be taken on the final STOP cycle so frames run back to back.
    assign accept   = (state == IDLE || (state == STOP && tick)) && hs == H_IDLE && in_rdy;
    assign last_bit = (bit_idx == BIT_WIDTH'(WIDTH - 1));
    assign busy     = (state != IDLE);
    assign in_done  = (hs == H_ACK);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_baud_tick (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hs    <= H_IDLE;
        end else begin
            state <= state_next;
            hs    <= hs_next;
        end
    end

    always_comb begin
        state_next = state;
        hs_next    = hs;
        txd        = TXD_IDLE;
        case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                txd = TXD_START;
                if (tick) state_next = DATA;
            end
            DATA: begin
                txd = shreg[0];
`ifdef UART_TX_PARITY_EN
                if (tick && last_bit) state_next = PARITY;
`else
                if (tick && last_bit) state_next = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd = parity_bit;
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) state_next = accept ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase

        case (hs)
            H_IDLE:  if (accept) hs_next = H_ACK;
            H_ACK:   if (!in_rdy) hs_next = H_IDLE;
            default: hs_next = H_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (accept) begin
            shreg   <= in_data;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^in_data;
`endif
        end else if (state == DATA && tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= last_bit ? '0 : bit_idx + BIT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx (CLKS_PER_BIT=4 and 2 instances).
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       in_rdy, in_done, txd, busy;
    logic [7:0] in_data;
    logic       rdy2, done2, txd2, busy2;
    logic [7:0] data2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .WIDTH       (8),
        .CLKS_PER_BIT(CPB),
        .CNT_WIDTH   (8),
        .BIT_WIDTH   (4)
    ) u1 (
        .clk    (clk),
        .reset  (reset),
        .in_rdy (in_rdy),
        .in_done(in_done),
        .in_data(in_data),
        .txd    (txd),
        .busy   (busy)
    );

    fifo_uart_tx #(
        .WIDTH       (8),
        .CLKS_PER_BIT(CPB2),
        .CNT_WIDTH   (8),
        .BIT_WIDTH   (4)
    ) u2 (
        .clk    (clk),
        .reset  (reset),
        .in_rdy (rdy2),
        .in_done(done2),
        .in_data(data2),
        .txd    (txd2),
        .busy   (busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot k of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic start(input logic [7:0] d);
        in_rdy  = 1'b1;
        in_data = d;
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        @(negedge clk);
        chk({tag, "_txd"}, txd, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, in_done, exp_done);
    endtask

    // Checks ncyc cycles of a frame starting the cycle after accept.
    task automatic run_frame(input string tag, input logic [7:0] d, input int drop_at,
                             input int raise_at, input logic [7:0] nd, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            chk($sformatf("%s_txd_c%0d", tag, c), txd, frame_bit(d, c / CPB));
            chk($sformatf("%s_busy_c%0d", tag, c), busy, 1'b1);
            chk($sformatf("%s_done_c%0d", tag, c), in_done,
                (drop_at < 0 || c <= drop_at) ? 1'b1 : 1'b0);
            if (c == drop_at) begin
                in_rdy  = 1'b0;
                in_data = ~d;
            end
            if (c == raise_at) begin
                in_rdy  = 1'b1;
                in_data = nd;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        in_rdy  = 1'b0;
        in_data = 8'h00;
        rdy2    = 1'b0;
        data2   = 8'h00;

        for (int i = 0; i < 3; i++) check_idle("reset", 1'b0);
        reset = 1'b0;
        check_idle("post_reset", 1'b0);
        check_idle("post_reset", 1'b0);

        reset  = 1'b1;
        in_rdy = 1'b1;
        in_data = 8'h77;
        check_idle("reset_rdy", 1'b0);
        check_idle("reset_rdy", 1'b0);
        reset  = 1'b0;
        in_rdy = 1'b0;
        check_idle("reset_rdy_rel", 1'b0);

        start(8'hA5);
        run_frame("a5", 8'hA5, 3, -1, 8'h00, NB * CPB);
        check_idle("a5_end", 1'b0);

        start(8'h00);
        run_frame("b2b0", 8'h00, 2, 10, 8'hFF, NB * CPB);
        run_frame("b2b1", 8'hFF, 1, -1, 8'h00, NB * CPB);
        check_idle("b2b_end", 1'b0);

        start(8'h96);
        run_frame("stuck", 8'h96, -1, -1, 8'h00, NB * CPB);
        for (int i = 0; i < 100; i++) check_idle("stuck_hold", 1'b1);
        in_rdy = 1'b0;
        check_idle("stuck_release", 1'b0);

        start(8'h3C);
        run_frame("midrst", 8'h3C, 0, -1, 8'h00, 18);
        reset = 1'b1;
        check_idle("midrst_abort", 1'b0);
        reset = 1'b0;
        check_idle("midrst_after", 1'b0);
        start(8'h5A);
        run_frame("after_rst", 8'h5A, 0, -1, 8'h00, NB * CPB);
        check_idle("after_rst_end", 1'b0);

        rdy2  = 1'b1;
        data2 = 8'h81;
        for (int c = 0; c < NB * CPB2; c++) begin
            @(negedge clk);
            chk($sformatf("cpb2_txd_c%0d", c), txd2, frame_bit(8'h81, c / CPB2));
            chk($sformatf("cpb2_busy_c%0d", c), busy2, 1'b1);
            if (c == 0) begin
                rdy2  = 1'b0;
                data2 = 8'h00;
            end
        end
        @(negedge clk);
        chk("cpb2_end_txd", txd2, 1'b1);
        chk("cpb2_end_busy", busy2, 1'b0);
        chk("cpb2_end_done", done2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
